// File: rtl/drr_pkg.sv
// Shared types and width helpers for the deficit round-robin scheduler.
package drr_pkg;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    EVAL  = 2'd1,
    GRANT = 2'd2
  } state_e;

  // Deficit needs one bit beyond the wider of packet size and quantum.
  function automatic int calc_dft_w(input int size_w, input int quantum_w);
    if (size_w > quantum_w) begin
      return size_w + 1;
    end else begin
      return quantum_w + 1;
    end
  endfunction

endpackage

// File: rtl/drr_deficit_bank.sv
// Per-flow deficit counters with saturating add, fit compare and subtract,
// all operating on the entry selected by idx_i.
module drr_deficit_bank import drr_pkg::*; #(
  parameter int PKT_QS_CNT = 4,
  parameter int SIZE_W     = 16,
  parameter int QUANTUM_W  = 16,
  parameter int DFT_W      = 17,
  parameter int IDX_W      = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IDX_W-1:0]     idx_i,
  input  logic                 add_en_i,
  input  logic                 clr_en_i,
  input  logic                 sub_en_i,
  input  logic [QUANTUM_W-1:0] quantum_i,
  input  logic [SIZE_W-1:0]    size_i,
  input  logic [SIZE_W-1:0]    sub_size_i,
  output logic                 fit_o
);

  localparam int SUM_W = DFT_W + 1;

  logic [DFT_W-1:0] deficit_q [PKT_QS_CNT];
  logic [DFT_W-1:0] deficit_d [PKT_QS_CNT];
  logic [DFT_W-1:0] cur_s;
  logic [SUM_W-1:0] sum_s;
  logic [DFT_W-1:0] sat_sum_s;
  logic [DFT_W-1:0] size_ext_s;
  logic [DFT_W-1:0] sub_ext_s;
  logic [DFT_W-1:0] diff_s;

  assign cur_s      = deficit_q[idx_i];
  assign sum_s      = {1'b0, cur_s} + SUM_W'(quantum_i);
  assign sat_sum_s  = sum_s[DFT_W] ? {DFT_W{1'b1}} : sum_s[DFT_W-1:0];
  assign size_ext_s = DFT_W'(size_i);
  assign sub_ext_s  = DFT_W'(sub_size_i);
  // Clamp at zero so a corrupted size can never wrap the counter.
  assign diff_s     = (sub_ext_s <= cur_s) ? (cur_s - sub_ext_s) : {DFT_W{1'b0}};
  assign fit_o      = (size_ext_s <= cur_s);

  always_comb begin
    deficit_d = deficit_q;
    if (clr_en_i) begin
      deficit_d[idx_i] = {DFT_W{1'b0}};
    end else if (add_en_i) begin
      deficit_d[idx_i] = sat_sum_s;
    end else if (sub_en_i) begin
      deficit_d[idx_i] = diff_s;
    end else begin
      deficit_d = deficit_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < PKT_QS_CNT; i++) begin
        deficit_q[i] <= {DFT_W{1'b0}};
      end
    end else begin
      deficit_q <= deficit_d;
    end
  end

endmodule

// File: rtl/drr_weighted_scheduler.sv
// Deficit round-robin scheduler: SCAN/EVAL/GRANT FSM with a round-robin
// pointer, driving the deficit bank and registering the grant outputs.
module drr_weighted_scheduler import drr_pkg::*; #(
  parameter  int PKT_QS_CNT = 4,
  parameter  int SIZE_W     = 16,
  parameter  int QUANTUM_W  = 16,
  localparam int DFT_W      = calc_dft_w(SIZE_W, QUANTUM_W),
  localparam int IDX_W      = $clog2(PKT_QS_CNT)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [PKT_QS_CNT-1:0]                pkt_val_i,
  input  logic [PKT_QS_CNT-1:0][SIZE_W-1:0]    size_i,
  input  logic [PKT_QS_CNT-1:0][QUANTUM_W-1:0] quantum_i,
  input  logic                                 ready_i,
  output logic [IDX_W-1:0]                     read_o,
  output logic [SIZE_W-1:0]                    read_size_o,
  output logic                                 read_val_o
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d, ptr_nxt_s;
  logic                read_val_q, read_val_d;
  logic [IDX_W-1:0]    read_idx_q, read_idx_d;
  logic [SIZE_W-1:0]   read_size_q, read_size_d;
  logic                add_en_s, clr_en_s, sub_en_s, fit_s;
  logic                val_sel_s;
  logic [SIZE_W-1:0]   size_sel_s;
  logic [QUANTUM_W-1:0] quantum_sel_s;

  assign val_sel_s     = pkt_val_i[ptr_q];
  assign size_sel_s    = size_i[ptr_q];
  assign quantum_sel_s = quantum_i[ptr_q];
  assign ptr_nxt_s     = (ptr_q == IDX_W'(PKT_QS_CNT - 1)) ? {IDX_W{1'b0}} : ptr_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    read_val_d  = read_val_q;
    read_idx_d  = read_idx_q;
    read_size_d = read_size_q;
    add_en_s    = 1'b0;
    clr_en_s    = 1'b0;
    sub_en_s    = 1'b0;
    case (state_q)
      SCAN: begin
        if (val_sel_s) begin
          add_en_s = 1'b1;
          state_d  = EVAL;
        end else begin
          clr_en_s = 1'b1;
          ptr_d    = ptr_nxt_s;
        end
      end
      EVAL: begin
        if (!val_sel_s) begin
          clr_en_s = 1'b1;
          ptr_d    = ptr_nxt_s;
          state_d  = SCAN;
        end else if (fit_s) begin
          read_val_d  = 1'b1;
          read_idx_d  = ptr_q;
          read_size_d = size_sel_s;
          state_d     = GRANT;
        end else begin
          ptr_d   = ptr_nxt_s;
          state_d = SCAN;
        end
      end
      GRANT: begin
        // Pointer still addresses the granted flow, so the bank debits ptr_q.
        if (read_val_q && ready_i) begin
          sub_en_s   = 1'b1;
          read_val_d = 1'b0;
          state_d    = EVAL;
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d    = SCAN;
        read_val_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= SCAN;
      ptr_q       <= {IDX_W{1'b0}};
      read_val_q  <= 1'b0;
      read_idx_q  <= {IDX_W{1'b0}};
      read_size_q <= {SIZE_W{1'b0}};
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      read_val_q  <= read_val_d;
      read_idx_q  <= read_idx_d;
      read_size_q <= read_size_d;
    end
  end

  drr_deficit_bank #(
    .PKT_QS_CNT (PKT_QS_CNT),
    .SIZE_W     (SIZE_W),
    .QUANTUM_W  (QUANTUM_W),
    .DFT_W      (DFT_W),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .idx_i      (ptr_q),
    .add_en_i   (add_en_s),
    .clr_en_i   (clr_en_s),
    .sub_en_i   (sub_en_s),
    .quantum_i  (quantum_sel_s),
    .size_i     (size_sel_s),
    .sub_size_i (read_size_q),
    .fit_o      (fit_s)
  );

  assign read_o      = read_idx_q;
  assign read_size_o = read_size_q;
  assign read_val_o  = read_val_q;

endmodule

// File: tb/tb_drr_weighted_scheduler.sv
// Self-checking bench: per-flow packet queues feed the scheduler and a
// transaction-level DRR model predicts the grant sequence and deficits.
module tb_drr_weighted_scheduler;

  localparam int N  = 4;
  localparam int SW = 16;
  localparam int QW = 16;
  localparam int DW = 17;
  localparam int IW = 2;
  localparam longint DMAX = (longint'(1) << DW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n = 1'b0;
  logic [N-1:0]          pkt_val = '0;
  logic [N-1:0][SW-1:0]  size = '0;
  logic [N-1:0][QW-1:0]  quantum = '0;
  logic                  ready = 1'b0;
  logic [IW-1:0]         read_idx;
  logic [SW-1:0]         read_size;
  logic                  read_val;

  logic                  rst3_n = 1'b0;
  logic [2:0]            pkt_val3 = '0;
  logic [2:0][SW-1:0]    size3 = '0;
  logic [2:0][QW-1:0]    quantum3 = '0;
  logic                  ready3 = 1'b0;
  logic [1:0]            read_idx3;
  logic [SW-1:0]         read_size3;
  logic                  read_val3;

  drr_weighted_scheduler #(.PKT_QS_CNT(N), .SIZE_W(SW), .QUANTUM_W(QW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pkt_val_i(pkt_val), .size_i(size),
    .quantum_i(quantum), .ready_i(ready), .read_o(read_idx),
    .read_size_o(read_size), .read_val_o(read_val)
  );

  drr_weighted_scheduler #(.PKT_QS_CNT(3), .SIZE_W(SW), .QUANTUM_W(QW)) dut3 (
    .clk_i(clk), .rst_ni(rst3_n), .pkt_val_i(pkt_val3), .size_i(size3),
    .quantum_i(quantum3), .ready_i(ready3), .read_o(read_idx3),
    .read_size_o(read_size3), .read_val_o(read_val3)
  );

  typedef struct {
    int idx;
    int sz;
    int def;
  } grant_t;

  int unsigned pq [N][$];
  grant_t      exp_q[$];
  grant_t      obs_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic drive_inputs();
    for (int f = 0; f < N; f++) begin
      pkt_val[f] = (pq[f].size() != 0);
      size[f]    = (pq[f].size() != 0) ? SW'(pq[f][0]) : SW'($urandom);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ready = 1'b0;
    for (int f = 0; f < N; f++) pq[f].delete();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Plain DRR: visit flows in order, top up, send while the head fits.
  task automatic build_model();
    int unsigned mq [N][$];
    longint      def [N];
    bool_loop: begin end
    exp_q.delete();
    for (int f = 0; f < N; f++) begin
      mq[f]  = pq[f];
      def[f] = 0;
    end
    for (int round = 0; round < 5000; round++) begin
      int left = 0;
      for (int f = 0; f < N; f++) left += mq[f].size();
      if (left == 0) break;
      for (int f = 0; f < N; f++) begin
        if (mq[f].size() == 0) begin
          def[f] = 0;
        end else begin
          def[f] = def[f] + longint'(quantum[f]);
          if (def[f] > DMAX) def[f] = DMAX;
          while (mq[f].size() != 0 && longint'(mq[f][0]) <= def[f]) begin
            def[f] = def[f] - longint'(mq[f][0]);
            exp_q.push_back('{f, int'(mq[f][0]), int'(def[f])});
            void'(mq[f].pop_front());
          end
          if (mq[f].size() == 0) def[f] = 0;
        end
      end
    end
  endtask

  task automatic run_traffic(input int n, input int rdy_pct, input int max_cycles,
                             output bit timeout);
    grant_t g;
    bit     hs;
    int     cyc = 0;
    obs_q.delete();
    drive_inputs();
    while (obs_q.size() < n && cyc < max_cycles) begin
      @(negedge clk);
      ready = ($urandom_range(99) < rdy_pct);
      hs    = read_val && ready;
      g.idx = int'(read_idx);
      g.sz  = int'(read_size);
      @(posedge clk);
      #1;
      if (hs) begin
        g.def = int'(dut.u_bank.deficit_q[g.idx]);
        obs_q.push_back(g);
        if (pq[g.idx].size() != 0) void'(pq[g.idx].pop_front());
        drive_inputs();
      end
      cyc++;
    end
    ready   = 1'b0;
    timeout = (obs_q.size() < n);
  endtask

  task automatic test_reset();
    pkt_val = '1;
    size    = '0;
    for (int f = 0; f < N; f++) quantum[f] = QW'(100);
    ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (read_val !== 1'b0 || read_idx !== '0 || read_size !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got val=%0b idx=%0d size=%0d, want 0 0 0",
               read_val, read_idx, read_size);
    end
    checks++;
    if (dut.ptr_q !== '0) begin
      errors++;
      $display("FAIL reset_ptr: got %0d, want 0", dut.ptr_q);
    end
    for (int f = 0; f < N; f++) begin
      checks++;
      if (dut.u_bank.deficit_q[f] !== '0) begin
        errors++;
        $display("FAIL reset_deficit%0d: got %0d, want 0", f, dut.u_bank.deficit_q[f]);
      end
    end
  endtask

  task automatic test_all_empty();
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ready = $urandom_range(1);
      checks++;
      if (read_val !== 1'b0) begin
        errors++;
        $display("FAIL empty_no_grant: cycle %0d got read_val=%0b, want 0", c, read_val);
      end
    end
    ready = 1'b0;
    for (int f = 0; f < N; f++) begin
      checks++;
      if (dut.u_bank.deficit_q[f] !== '0) begin
        errors++;
        $display("FAIL empty_deficit%0d: got %0d, want 0", f, dut.u_bank.deficit_q[f]);
      end
    end
  endtask

  task automatic test_quantum_carry();
    int exp_def [3] = '{200, 400, 100};
    bit to;
    for (int f = 0; f < N; f++) quantum[f] = QW'(500);
    apply_reset();
    for (int k = 0; k < 5; k++) pq[0].push_back(300);
    run_traffic(3, 100, 200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL carry_timeout: got %0d grants, want 3", obs_q.size());
    end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].idx != 0 || obs_q[i].sz != 300 || obs_q[i].def != exp_def[i]) begin
        errors++;
        $display("FAIL carry_grant%0d: got flow=%0d size=%0d def=%0d, want 0 300 %0d",
                 i, obs_q[i].idx, obs_q[i].sz, obs_q[i].def, exp_def[i]);
      end
    end
  endtask

  task automatic test_ratio();
    int q_tab [N]   = '{1000, 500, 250, 250};
    int exp_cnt [N] = '{40, 20, 10, 10};
    int cnt [N]     = '{0, 0, 0, 0};
    bit to;
    for (int f = 0; f < N; f++) quantum[f] = QW'(q_tab[f]);
    apply_reset();
    for (int f = 0; f < N; f++)
      for (int k = 0; k < 100; k++) pq[f].push_back(250);
    build_model();
    run_traffic(80, 100, 2000, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL ratio_timeout: got %0d grants, want 80", obs_q.size());
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      cnt[obs_q[i].idx]++;
      checks++;
      if (obs_q[i].idx != exp_q[i].idx || obs_q[i].sz != exp_q[i].sz ||
          obs_q[i].def != exp_q[i].def) begin
        errors++;
        $display("FAIL ratio_seq%0d: got flow=%0d def=%0d, want flow=%0d def=%0d",
                 i, obs_q[i].idx, obs_q[i].def, exp_q[i].idx, exp_q[i].def);
      end
    end
    for (int f = 0; f < N; f++) begin
      checks++;
      if (cnt[f] != exp_cnt[f]) begin
        errors++;
        $display("FAIL ratio_count%0d: got %0d, want %0d", f, cnt[f], exp_cnt[f]);
      end
    end
  endtask

  task automatic test_stall();
    bit seen = 1'b0;
    for (int f = 0; f < N; f++) quantum[f] = QW'(500);
    apply_reset();
    pq[1].push_back(120);
    pq[1].push_back(1000);
    drive_inputs();
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = read_val;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_no_grant: got no grant in 50 cycles, want one");
      return;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (read_val !== 1'b1 || read_idx !== 2'd1 || read_size !== 16'd120 ||
          dut.u_bank.deficit_q[1] !== 17'd500) begin
        errors++;
        $display("FAIL stall_hold%0d: got val=%0b idx=%0d size=%0d def=%0d, want 1 1 120 500",
                 c, read_val, read_idx, read_size, dut.u_bank.deficit_q[1]);
      end
    end
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    void'(pq[1].pop_front());
    drive_inputs();
    checks++;
    if (dut.u_bank.deficit_q[1] !== 17'd380 || read_val !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept: got def=%0d val=%0b, want 380 0",
               dut.u_bank.deficit_q[1], read_val);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.u_bank.deficit_q[1] !== 17'd380 || dut.ptr_q !== 2'd2) begin
      errors++;
      $display("FAIL stall_single_dec: got def=%0d ptr=%0d, want 380 2",
               dut.u_bank.deficit_q[1], dut.ptr_q);
    end
  endtask

  task automatic test_empty_clear();
    bit to;
    quantum[0] = QW'(500);
    quantum[1] = QW'(500);
    quantum[2] = QW'(400);
    quantum[3] = QW'(500);
    apply_reset();
    pq[2].push_back(250);
    run_traffic(1, 100, 100, to);
    checks++;
    if (to || obs_q[0].idx != 2 || obs_q[0].def != 150) begin
      errors++;
      $display("FAIL clear_grant: got grants=%0d, want flow 2 def 150", obs_q.size());
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.u_bank.deficit_q[2] !== '0 || dut.ptr_q !== 2'd3) begin
      errors++;
      $display("FAIL clear_eval: got def=%0d ptr=%0d, want 0 3",
               dut.u_bank.deficit_q[2], dut.ptr_q);
    end
  endtask

  task automatic test_random();
    bit to;
    for (int it = 0; it < 3; it++) begin
      for (int f = 0; f < 3; f++) quantum[f] = QW'($urandom_range(600, 1));
      quantum[3] = '0;
      apply_reset();
      for (int f = 0; f < 3; f++) begin
        int len = $urandom_range(12);
        for (int k = 0; k < len; k++)
          pq[f].push_back(($urandom_range(7) == 0) ? 0 : $urandom_range(700));
      end
      for (int k = 0; k < int'($urandom_range(4)); k++) pq[3].push_back(0);
      build_model();
      run_traffic(exp_q.size(), 60, 20000, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL random%0d_timeout: got %0d grants, want %0d", it, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i].idx != exp_q[i].idx || obs_q[i].sz != exp_q[i].sz ||
            obs_q[i].def != exp_q[i].def) begin
          errors++;
          $display("FAIL random%0d_seq%0d: got flow=%0d size=%0d def=%0d, want %0d %0d %0d",
                   it, i, obs_q[i].idx, obs_q[i].sz, obs_q[i].def,
                   exp_q[i].idx, exp_q[i].sz, exp_q[i].def);
        end
      end
    end
  endtask

  task automatic test_wrap3();
    bit seen = 1'b0;
    int exp_ptr [3] = '{1, 2, 0};
    rst3_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst3_n   = 1'b1;
    pkt_val3 = 3'b100;
    size3[2] = 16'd50;
    for (int f = 0; f < 3; f++) quantum3[f] = QW'(100);
    ready3 = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      seen = read_val3;
    end
    checks++;
    if (!seen || read_idx3 !== 2'd2 || read_size3 !== 16'd50) begin
      errors++;
      $display("FAIL wrap3_grant: got val=%0b idx=%0d size=%0d, want 1 2 50",
               read_val3, read_idx3, read_size3);
    end
    rst3_n = 1'b0;
    ready3 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (read_val3 !== 1'b0 || read_idx3 !== '0 || read_size3 !== '0 ||
        dut3.ptr_q !== '0 || dut3.u_bank.deficit_q[2] !== '0) begin
      errors++;
      $display("FAIL wrap3_reset: got val=%0b idx=%0d size=%0d ptr=%0d def=%0d, want all 0",
               read_val3, read_idx3, read_size3, dut3.ptr_q, dut3.u_bank.deficit_q[2]);
    end
    @(negedge clk);
    pkt_val3 = '0;
    ready3   = 1'b0;
    rst3_n   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (dut3.ptr_q !== 2'(exp_ptr[k]) || read_val3 !== 1'b0) begin
        errors++;
        $display("FAIL wrap3_ptr%0d: got ptr=%0d val=%0b, want %0d 0",
                 k, dut3.ptr_q, read_val3, exp_ptr[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_empty();
    test_quantum_carry();
    test_ratio();
    test_stall();
    test_empty_clear();
    test_random();
    test_wrap3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/drr_weighted_scheduler.md
DRR_WEIGHTED_SCHEDULER -- requirements
Module: drr_weighted_scheduler

Interface
REQ-001 SHALL have parameter PKT_QS_CNT, default 4: number of flows (any value >= 2, power of two not required).
REQ-002 SHALL have parameter SIZE_W, default 16: packet size width in bytes.
REQ-003 SHALL have parameter QUANTUM_W, default 16: per-flow quantum width.
REQ-004 SHALL have derived localparam DFT_W = max(SIZE_W, QUANTUM_W) + 1 (deficit counter width) and IDX_W = $clog2(PKT_QS_CNT).
REQ-005 SHALL have port clk_i, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port pkt_val_i, input, [PKT_QS_CNT]: flow has a head-of-line packet.
REQ-008 SHALL have port size_i, input, [PKT_QS_CNT][SIZE_W]: head packet size per flow, valid only when the matching pkt_val_i bit is 1.
REQ-009 SHALL have port quantum_i, input, [PKT_QS_CNT][QUANTUM_W]: per-flow quantum (weight), quasi-static.
REQ-010 SHALL have port ready_i, input, 1: downstream accepts the grant.
REQ-011 SHALL have port read_o, output, IDX_W: granted flow index.
REQ-012 SHALL have port read_size_o, output, SIZE_W: granted packet size.
REQ-013 SHALL have port read_val_o, output, 1: grant valid.

Function
REQ-014 SHALL run an FSM with states SCAN, EVAL and GRANT, plus a round-robin pointer ptr and one DFT_W deficit counter per flow.
REQ-015 In SCAN with pkt_val_i[ptr]=0: deficit[ptr] <= 0, ptr advances, state stays SCAN.
REQ-016 In SCAN with pkt_val_i[ptr]=1: deficit[ptr] <= deficit[ptr] + quantum_i[ptr], saturating at 2^DFT_W-1; next state EVAL.
REQ-017 In EVAL with pkt_val_i[ptr]=1 and size_i[ptr] <= deficit[ptr]: register read_o=ptr, read_size_o=size_i[ptr], read_val_o=1; next state GRANT.
REQ-018 In EVAL with pkt_val_i[ptr]=0: deficit[ptr] <= 0, ptr advances, next state SCAN.
REQ-019 In EVAL with size_i[ptr] > deficit[ptr]: deficit is retained, ptr advances, next state SCAN.
REQ-020 In GRANT, read_val_o, read_o and read_size_o SHALL hold stable while ready_i=0.
REQ-021 In GRANT on read_val_o && ready_i: deficit[read_o] <= deficit[read_o] - read_size_o (never underflows), read_val_o <= 0, next state EVAL with ptr unchanged.
REQ-022 The upstream queue SHALL update pkt_val_i and size_i by the cycle after a handshake; the EVAL bubble guarantees this, so peak throughput is one grant per 2 cycles.
REQ-023 Pointer advance SHALL wrap PKT_QS_CNT-1 -> 0.
REQ-024 ready_i while read_val_o=0 SHALL be ignored.
REQ-025 A size 0 packet SHALL always be grantable in EVAL.
REQ-026 quantum_i[ptr]=0 SHALL add nothing; that flow is served only for size-0 packets.
REQ-027 With all flows empty, the FSM SHALL cycle through SCAN with no grants and all deficits at 0.
REQ-028 Grant-to-acceptance latency SHALL be unbounded; no timeout.

Reset
REQ-029 While rst_ni=0 at a clock edge: state <= SCAN, ptr <= 0, every deficit <= 0, read_val_o <= 0, read_o <= 0, read_size_o <= 0.
REQ-030 Reset mid-GRANT SHALL drop the grant without a handshake; no deficit update is applied for that cycle.
REQ-031 The first SCAN after reset release SHALL occur on the first edge with rst_ni=1.

Structure
REQ-032 The state enum (SCAN, EVAL, GRANT) and a function computing DFT_W SHALL live in shared package drr_pkg.
REQ-033 The saturating add, compare and subtract datapath SHALL live in one sub-module, drr_deficit_bank, holding the counter array; the FSM and pointer stay in the top module.

Verification
REQ-034 Bench SHALL cover: reset, all flows empty for 20 cycles -> read_val_o never 1, all deficits 0.
REQ-035 Bench SHALL cover: quantum=500 all flows, flow 0 backlogged with size 300, ready_i=1 -> one grant for flow 0 (deficit 200), then the next SCAN of flow 0 gives 700 -> two grants (deficit 100).
REQ-036 Bench SHALL cover: quanta {1000,500,250,250}, all flows backlogged with size 250 -> grants in the ratio 4:2:1:1 over 80 grants.
REQ-037 Bench SHALL cover: ready_i held 0 for 10 cycles during GRANT -> read_o and read_size_o stable, no deficit change; ready_i=1 -> a single decrement.
REQ-038 Bench SHALL cover: flow 2 empties after a grant with deficit 150 -> deficit[2] = 0 at its next EVAL and ptr = 3.
REQ-039 Bench SHALL cover: PKT_QS_CNT=3, rst_ni=0 asserted during GRANT -> outputs 0 next cycle, and ptr wraps 2 -> 0 after release.
